// File: rtl/basys_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | basys_pkg                                                                  |
// | Shared button indices, display source encodings and hex segment table.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package basys_pkg;

  localparam int BTN_U = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int BTN_D = 3;

  typedef enum logic [1:0] {
    SRC_EVT    = 2'b00,
    SRC_SW     = 2'b01,
    SRC_CYC_HI = 2'b10,
    SRC_CYC_LO = 2'b11
  } src_sel_e;

  // Active-low gfedcba patterns, entry 0 in the least significant slot.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_mux                                                                   |
// | Multiplexed 4-digit hex driver with registered segment/anode/dp outputs.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg7_mux #(
  parameter int REFRESH_BITS = 17
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_value,
  input  logic        i_hold,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [3:0]  o_an
);
  import basys_pkg::*;

  logic [REFRESH_BITS-1:0] r_refresh;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [3:0]              r_an;
  logic [1:0]              w_digit;
  logic [3:0]              w_nibble;

  assign w_digit  = r_refresh[REFRESH_BITS-1 -: 2];
  assign w_nibble = i_value[{w_digit, 2'b00} +: 4];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_refresh <= '0;
      r_seg     <= 7'h7F;
      r_dp      <= 1'b1;
      r_an      <= 4'hF;
    end else begin
      r_refresh <= r_refresh + 1'b1;
      r_an      <= ~(4'b0001 << w_digit);
      r_seg     <= hex_to_seg(w_nibble);
      // Lit decimal point on the rightmost digit flags a frozen display.
      r_dp      <= !((w_digit == 2'd0) && i_hold);
    end
  end

  assign o_seg = r_seg;
  assign o_dp  = r_dp;
  assign o_an  = r_an;

endmodule
`default_nettype wire

// File: rtl/basys_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | basys_top                                                                  |
// | Basys3 board top: reset sync, cycle/event counters, LEDs, 7-seg display.   |
// | Optional macro BASYS_DEBOUNCE_EN enables the button debounce counters.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module basys_top #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_BITS    = 17,
  parameter int HEARTBEAT_BIT   = 26
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_sw,
  input  logic [3:0]  i_btn,
  output logic [15:0] o_led,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [3:0]  o_an
);
  import basys_pkg::*;

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [1:0]  r_rst_sync;
  logic        w_rstn;
  logic [15:0] r_sw_meta, r_sw_s;
  logic [3:0]  r_btn_meta, r_btn_s;
  logic [3:0]  w_btn_db, r_btn_db_d, w_btn_pulse;
  logic [31:0] r_cycle;
  logic [15:0] r_evt, r_hold_val, r_led;
  logic        r_hold;
  logic [15:0] w_src, w_disp;

  // Assertion is immediate; release waits two clock edges.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_rst_sync <= '0;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rstn = r_rst_sync[1];

  always_ff @(posedge i_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_sw_meta  <= '0;
      r_sw_s     <= '0;
      r_btn_meta <= '0;
      r_btn_s    <= '0;
    end else begin
      r_sw_meta  <= i_sw;
      r_sw_s     <= r_sw_meta;
      r_btn_meta <= i_btn;
      r_btn_s    <= r_btn_meta;
    end
  end

`ifdef BASYS_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic [DB_W-1:0] r_cnt;
    logic            r_level;
    always_ff @(posedge i_clk or negedge w_rstn) begin
      if (!w_rstn) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
      end else if (r_btn_s[gi] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_btn_s[gi];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign w_btn_db[gi] = r_level;
  end
`else
  assign w_btn_db = r_btn_s;
`endif

  always_ff @(posedge i_clk or negedge w_rstn) begin
    if (!w_rstn) r_btn_db_d <= '0;
    else         r_btn_db_d <= w_btn_db;
  end
  assign w_btn_pulse = w_btn_db & ~r_btn_db_d;

  always_comb begin
    w_src = r_evt;
    case (src_sel_e'(r_sw_s[15:14]))
      SRC_EVT:    w_src = r_evt;
      SRC_SW:     w_src = {2'b00, r_sw_s[13:0]};
      SRC_CYC_HI: w_src = r_cycle[31:16];
      SRC_CYC_LO: w_src = r_cycle[15:0];
      default:    w_src = r_evt;
    endcase
  end
  assign w_disp = r_hold ? r_hold_val : w_src;

  always_ff @(posedge i_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      r_cycle    <= '0;
      r_evt      <= '0;
      r_hold     <= 1'b0;
      r_hold_val <= '0;
      r_led      <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      // Clear wins; simultaneous up and down cancel.
      if (w_btn_pulse[BTN_L])
        r_evt <= '0;
      else if (w_btn_pulse[BTN_U] && !w_btn_pulse[BTN_D])
        r_evt <= r_evt + 16'd1;
      else if (w_btn_pulse[BTN_D] && !w_btn_pulse[BTN_U])
        r_evt <= r_evt - 16'd1;
      if (w_btn_pulse[BTN_R]) begin
        r_hold <= !r_hold;
        if (!r_hold) r_hold_val <= w_src;
      end
      r_led <= {r_cycle[HEARTBEAT_BIT], r_hold, r_sw_s[13:0]};
    end
  end

  assign o_led = r_led;

  seg7_mux #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_seg7_mux (
    .i_clk  (i_clk),
    .i_rstn (w_rstn),
    .i_value(w_disp),
    .i_hold (r_hold),
    .o_seg  (o_seg),
    .o_dp   (o_dp),
    .o_an   (o_an)
  );

endmodule
`default_nettype wire

// File: tb/tb_basys_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_basys_top                                                               |
// | Directed bench for basys_top with a cycle-level reference model.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_basys_top;
  localparam int DEB = 4;
  localparam int RB  = 4;
  localparam int HB  = 3;
  localparam logic [6:0] TB_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] sw  = '0;
  logic [3:0]  btn = '0;
  logic [15:0] led;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  basys_top #(
    .DEBOUNCE_CYCLES(DEB),
    .REFRESH_BITS   (RB),
    .HEARTBEAT_BIT  (HB)
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .i_sw  (sw),
    .i_btn (btn),
    .o_led (led),
    .o_seg (seg),
    .o_dp  (dp),
    .o_an  (an)
  );

  // Reference model state
  int          m_age;
  int          m_tick;
  int          m_run [4];
  logic [15:0] m_sw1, m_sw_s;
  logic [3:0]  m_b1, m_b_s, m_lvl, m_lvl_d;
  logic [31:0] m_cyc;
  logic [15:0] m_evt, m_hval;
  logic        m_hold;
  logic [15:0] m_led;
  logic [6:0]  m_seg;
  logic        m_dp;
  logic [3:0]  m_an;

  always @(posedge clk or negedge rstn) begin : model
    logic [15:0] src, disp;
    logic [3:0]  lvl, pulse;
    int          k;
    if (!rstn) begin
      m_age = 0; m_tick = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_sw1 = '0; m_sw_s = '0; m_b1 = '0; m_b_s = '0; m_lvl = '0; m_lvl_d = '0;
      m_cyc = '0; m_evt = '0; m_hval = '0; m_hold = 1'b0;
      m_led = '0; m_seg = 7'h7F; m_dp = 1'b1; m_an = 4'hF;
    end else if (m_age < 2) begin
      m_age = m_age + 1;
    end else begin
      case (m_sw_s[15:14])
        2'b00:   src = m_evt;
        2'b01:   src = {2'b00, m_sw_s[13:0]};
        2'b10:   src = m_cyc[31:16];
        default: src = m_cyc[15:0];
      endcase
      disp = m_hold ? m_hval : src;
      k = (m_tick >> (RB - 2)) & 3;
      m_an  = ~(4'b0001 << k);
      m_seg = TB_HEX[(disp >> (4 * k)) & 16'hF];
      m_dp  = !(k == 0 && m_hold);
      m_led = {m_cyc[HB], m_hold, m_sw_s[13:0]};
`ifdef BASYS_DEBOUNCE_EN
      lvl = m_lvl;
`else
      lvl = m_b_s;
`endif
      pulse = lvl & ~m_lvl_d;
      if (pulse[1])                m_evt = 16'h0000;
      else if (pulse[0] && pulse[3]) m_evt = m_evt;
      else if (pulse[0])           m_evt = m_evt + 16'd1;
      else if (pulse[3])           m_evt = m_evt - 16'd1;
      if (pulse[2]) begin
        if (!m_hold) m_hval = src;
        m_hold = !m_hold;
      end
      m_lvl_d = lvl;
`ifdef BASYS_DEBOUNCE_EN
      for (int i = 0; i < 4; i++) begin
        if (m_b_s[i] == m_lvl[i]) m_run[i] = 0;
        else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_lvl[i] = m_b_s[i];
            m_run[i] = 0;
          end
        end
      end
`endif
      m_b_s = m_b1;  m_b1  = btn;
      m_sw_s = m_sw1; m_sw1 = sw;
      m_cyc  = m_cyc + 32'd1;
      m_tick = m_tick + 1;
    end
  end

  always @(negedge clk) begin : compare
    n_total++;
    if ({led, seg, dp, an} === {m_led, m_seg, m_dp, m_an}) n_pass++;
    else $display("FAIL model t=%0t actual led=%h seg=%h dp=%b an=%b required led=%h seg=%h dp=%b an=%b",
                  $time, led, seg, dp, an, m_led, m_seg, m_dp, m_an);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] m, input int hi);
    cycles(1);
    btn = m;
    cycles(hi);
    btn = '0;
    cycles(12);
  endtask

  task automatic wait_digit(input logic [3:0] want, input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (an !== want && t < 20) begin
      @(negedge clk);
      t++;
    end
    check(name, an, want);
  endtask

  task automatic read_display(output logic [15:0] v);
    v = 16'hxxxx;
    repeat (16) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (an == ~(4'b0001 << d))
          for (int h = 0; h < 16; h++)
            if (seg == TB_HEX[h]) v[4*d +: 4] = h[3:0];
    end
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] v;
    logic        hb;
    int          t;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_led", led, 16'h0000);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp",  dp,  1'b1);
    check("rst_an",  an,  4'hF);
    rstn = 1'b1;

    // Heartbeat period on led[15]
    t = 0; hb = led[15];
    while (led[15] === hb && t < 40) begin @(negedge clk); t++; end
    hb = led[15]; t = 0;
    while (led[15] === hb && t < 40) begin @(negedge clk); t++; end
    check("heartbeat_period", t, 8);

    // Switch source: value 0x1234
    cycles(1);
    sw = 16'h5234;
    cycles(4);
    check("led_sw", led[13:0], 14'h1234);
    wait_digit(4'b1110, "dig0_an"); check("dig0_seg", seg, 7'b0011001);
    wait_digit(4'b1101, "dig1_an"); check("dig1_seg", seg, 7'h30);
    wait_digit(4'b1011, "dig2_an"); check("dig2_seg", seg, 7'h24);
    wait_digit(4'b0111, "dig3_an"); check("dig3_seg", seg, 7'h79);

    // Debounce behaviour
    sw = 16'h0000;
    cycles(4);
    press(4'b0001, 2);
    read_display(v);
`ifdef BASYS_DEBOUNCE_EN
    check("short_press", v, 16'h0000);
`else
    check("short_press", v, 16'h0001);
`endif
    press(4'b0010, 10);
    press(4'b0001, 10);
    read_display(v);
    check("long_press", v, 16'h0001);

    // Counter arithmetic
    press(4'b0010, 10);
    press(4'b0001, 10);
    press(4'b0001, 10);
    press(4'b1000, 10);
    read_display(v); check("uud", v, 16'h0001);
    press(4'b0010, 10);
    read_display(v); check("clear", v, 16'h0000);
    press(4'b1000, 10);
    read_display(v); check("wrap_down", v, 16'hFFFF);
    press(4'b1001, 10);
    read_display(v); check("u_and_d", v, 16'hFFFF);
    press(4'b0011, 10);
    read_display(v); check("l_and_u", v, 16'h0000);

    // Hold on a fast-moving source
    sw = 16'hC000;
    cycles(4);
    press(4'b0100, 10);
    check("hold_led", led[14], 1'b1);
    read_display(v); check("hold_frozen", v, m_hval);
    cycles(20);
    read_display(v); check("hold_still", v, m_hval);
    wait_digit(4'b1110, "hold_dig0_an");
    check("hold_dp0", {dp, seg}, {1'b0, TB_HEX[m_hval[3:0]]});
    wait_digit(4'b1101, "hold_dig1_an");
    check("hold_dp1", dp, 1'b1);
    press(4'b0100, 10);
    check("unhold_led", led[14], 1'b0);
    wait_digit(4'b1110, "unhold_dig0_an");
    check("unhold_dp0", dp, 1'b1);

    // Mid-run reset
    sw = 16'h0000;
    cycles(4);
    press(4'b0010, 10);
    repeat (5) press(4'b0001, 10);
    read_display(v); check("evt_five", v, 16'h0005);
    press(4'b0100, 10);
    check("mr_hold_before", led[14], 1'b1);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("mr_an",  an,  4'hF);
    check("mr_led", led, 16'h0000);
    check("mr_seg", seg, 7'h7F);
    check("mr_dp",  dp,  1'b1);
    @(negedge clk);
    #1 rstn = 1'b1;
    cycles(6);
    check("mr_hold_after", led[14], 1'b0);
    read_display(v); check("mr_evt", v, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/basys_top.md
Name: basys_top

Overview:
- Board-level top for the Basys3 FPGA board.
- Provides:
  - reset conditioning
  - a free-running cycle counter
  - button debouncing and a button-driven 16-bit event counter
  - switch-to-LED mirroring
  - a 4-digit multiplexed hex 7-segment display with a switch-selected source.
- Sits at the top of the hierarchy; ports map directly to board pins.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples needed to accept a button level change.
- REFRESH_BITS, 17: width of the display refresh counter. Its top 2 bits select the active digit.
- HEARTBEAT_BIT, 26: cycle-counter bit driven to o_led[15].

Ports:
- i_clk  in  1  100 MHz board clock.
- i_rstn  in  1  asynchronous active-low reset. Bench must drive it; on the board it is held high by a pull-up.
- i_sw  in  16  slide switches, asynchronous.
- i_btn  in  4  push buttons, asynchronous, active-high: [0]=U, [1]=L, [2]=R, [3]=D.
- o_led  out  16  LEDs.
- o_seg  out  7  segments a..g, active-low ([0]=a).
- o_dp  out  1  decimal point, active-low.
- o_an  out  4  digit anodes, active-low ([0]=rightmost).

Behaviour:
- Reset:
  - i_rstn low asynchronously clears all flops.
  - Release is synchronized by a 2-flop synchronizer. Internal logic leaves reset on the 2nd rising edge after i_rstn goes high.
  - Reset values: o_led=0, o_seg=7'h7F, o_dp=1, o_an=4'hF. All counters, hold and debounced levels = 0.
- Cycle counter:
  - 32-bit, increments every cycle out of reset.
  - Wraps 0xFFFFFFFF->0.
- Inputs: i_sw and i_btn each pass through a 2-flop synchronizer.
- Debounce (per button):
  - Counter resets whenever the synced level equals the debounced level.
  - Otherwise it counts; on reaching DEBOUNCE_CYCLES the debounced level takes the synced level.
  - A rising edge of the debounced level yields a 1-cycle pulse.
- Event counter (16-bit), evaluated on each cycle's pulses, in priority order:
  - L pulse: clear to 0.
  - U and D together: no change.
  - U: +1.
  - D: -1.
  - Wraps both directions: 0xFFFF+1=0, 0-1=0xFFFF.
- Hold:
  - R pulse toggles hold.
  - While hold=1, the displayed 16-bit value is frozen. It is latched from the selected source on the cycle hold rises.
- Display source, selected by synced sw[15:14]:
  - 00 = event counter
  - 01 = {2'b00, sw[13:0]}
  - 10 = cycle[31:16]
  - 11 = cycle[15:0]
- LEDs (registered):
  - o_led[13:0] = synced sw[13:0]
  - o_led[14] = hold
  - o_led[15] = cycle[HEARTBEAT_BIT]
- 7-segment:
  - Refresh counter width REFRESH_BITS, free-running.
  - digit index k = counter top 2 bits; o_an = ~(1<<k).
  - Nibble shown = value[4k+3:4k], standard hex decode (0=7'b1000000 as gfedcba, ... F).
  - o_dp = 0 only on digit 0 while hold=1, else 1.
  - Outputs registered: 1-cycle latency from counter/value to pins.
- Reset asserted mid-operation: immediate return to reset values, including hold and event counter.

Optional Feature:
- Macro BASYS_DEBOUNCE_EN.
- Defined: debounce as specified.
- Undefined: debounce counters removed; debounced level = synced level. Edge pulse is generated directly, so button response is 1 cycle after synchronization.

Decomposition:
- Package basys_pkg holds:
  - button index constants (BTN_U=0, BTN_L=1, BTN_R=2, BTN_D=3)
  - source-select encodings (SRC_EVT, SRC_SW, SRC_CYC_HI, SRC_CYC_LO)
  - the 16-entry hex-to-segment constant table.
- One sub-module, seg7_mux: inputs clock, reset and 16-bit value, plus hold for dp; outputs o_seg, o_dp, o_an. Contains the refresh counter and hex decoder.

Test Plan (DEBOUNCE_CYCLES=4, REFRESH_BITS=4, HEARTBEAT_BIT=3, 10 ns clock):
1. Reset and heartbeat:
   - Stimulus: i_rstn=0 for 3 cycles, then release; sw/btn=0; run 250 ns.
   - Response: reset values during reset; cycle counter =1 two edges after release; o_led[15] toggles every 8 cycles; no X on any output.
2. Switch display:
   - Stimulus: sw=16'h5234 (sel 01 -> value 0x1234).
   - Response: o_an steps 1110 (seg '4'=7'b0011001), 1101 ('3'), 1011 ('2'), 0111 ('1'); o_led[13:0]=0x1234.
3. Debounce:
   - Stimulus: U high 2 cycles then low.
   - Response: event counter stays 0.
   - Stimulus: U high 10 cycles.
   - Response: event counter = 1.
4. Counter arithmetic:
   - Stimulus: U,U,D.
   - Response: 1.
   - Stimulus: L.
   - Response: 0.
   - Stimulus: D.
   - Response: 0xFFFF (sel 00 displays FFFF).
   - Stimulus: U+D same cycle.
   - Response: unchanged.
   - Stimulus: L+U.
   - Response: 0.
5. Hold:
   - Stimulus: sel 11, press R.
   - Response: displayed value frozen while cycle counter advances; o_led[14]=1; dp lit on digit 0.
   - Stimulus: press R again.
   - Response: display tracks the source again.
6. Mid-run reset:
   - Stimulus: event counter=5, hold=1, pulse i_rstn low 1 cycle.
   - Response: counter=0, hold=0, o_an=4'hF immediately.
